// File: rtl/spike_packet_scheduler.sv
// Round-robin spike arbiter emitting {origin, destination} packets; optional SPIKE_SCHED_COALESCE_CNT_EN adds coalesced_count.
// Spike to first packet_valid: 3 cycles from IDLE; packet_valid/packet hold until packet_ready, pending spikes queue meanwhile.
module spike_packet_scheduler #(
  parameter int NUM_NEURONS = 10,
  parameter int MAX_FANOUT  = 5,
  parameter int ADDR_W      = 12,
  parameter int CNT_W       = 3
) (
  input  logic                                     CLK,
  input  logic                                     clear,
  input  logic [NUM_NEURONS-1:0]                   spikes,
  input  logic [ADDR_W*NUM_NEURONS-1:0]            neuron_addresses,
  input  logic [ADDR_W*MAX_FANOUT*NUM_NEURONS-1:0] downstream_connections,
  input  logic [CNT_W*NUM_NEURONS-1:0]             fanout_counts,
  output logic [2*ADDR_W-1:0]                      packet,
  output logic                                     packet_valid,
  input  logic                                     packet_ready,
`ifdef SPIKE_SCHED_COALESCE_CNT_EN
  output logic [15:0]                              coalesced_count,
`endif
  output logic                                     busy
);

  localparam int SEL_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [SEL_W:0]   NUM_EXT  = (SEL_W+1)'(NUM_NEURONS);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_NEURONS-1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_FANOUT);

  typedef enum logic [1:0] {IDLE, SELECT, EMIT} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [NUM_NEURONS-1:0] r_pend;
  logic [NUM_NEURONS-1:0] w_clr_mask;
  logic [SEL_W-1:0]       r_sel;
  logic [SEL_W-1:0]       r_rr_ptr;
  logic [CNT_W-1:0]       r_idx;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_valid;

  logic [SEL_W:0]         w_cand;
  logic [SEL_W-1:0]       w_pick;
  logic                   w_found;
  logic [CNT_W-1:0]       w_fo_raw;
  logic [CNT_W-1:0]       w_fo_cnt;
  logic [SEL_W-1:0]       w_pick_inc;
  logic [SEL_W-1:0]       w_sel_inc;
  logic                   w_xfer;
  logic                   w_last;
  logic [ADDR_W-1:0]      w_org;
  logic [ADDR_W-1:0]      w_dst;

  // First pending neuron at or above rr_ptr, wrapping past the top.
  always_comb begin
    w_pick  = r_rr_ptr;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NUM_NEURONS; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (SEL_W+1)'(k);
      if (w_cand >= NUM_EXT) w_cand = w_cand - NUM_EXT;
      if (!w_found && r_pend[w_cand[SEL_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[SEL_W-1:0];
      end
    end
  end

  assign w_fo_raw   = fanout_counts[int'(w_pick)*CNT_W +: CNT_W];
  assign w_fo_cnt   = (w_fo_raw > MAX_CNT) ? MAX_CNT : w_fo_raw;
  assign w_pick_inc = (w_pick == LAST_SEL) ? '0 : w_pick + SEL_W'(1);
  assign w_sel_inc  = (r_sel == LAST_SEL) ? '0 : r_sel + SEL_W'(1);
  assign w_xfer     = r_valid && packet_ready;
  assign w_last     = (r_idx == r_cnt - CNT_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_clr_mask  = '0;
    unique case (r_state)
      IDLE: begin
        if (|r_pend) w_state_nxt = SELECT;
      end
      SELECT: begin
        if (w_found) w_clr_mask = {{(NUM_NEURONS-1){1'b0}}, 1'b1} << w_pick;
        if (!w_found || w_fo_cnt == '0) w_state_nxt = IDLE;
        else                            w_state_nxt = EMIT;
      end
      EMIT: begin
        if (w_xfer && w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A spike arriving on the bit being cleared re-queues it (set wins).
  always_ff @(posedge CLK) begin
    if (clear) begin
      r_state  <= IDLE;
      r_pend   <= '0;
      r_sel    <= '0;
      r_rr_ptr <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= (r_pend & ~w_clr_mask) | spikes;
      r_valid <= (w_state_nxt == EMIT);
      case (r_state)
        SELECT: begin
          if (w_found) begin
            r_sel <= w_pick;
            r_idx <= '0;
            r_cnt <= w_fo_cnt;
            if (w_fo_cnt == '0) r_rr_ptr <= w_pick_inc;
          end
        end
        EMIT: begin
          if (w_xfer) begin
            if (w_last) r_rr_ptr <= w_sel_inc;
            else        r_idx    <= r_idx + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign w_org        = neuron_addresses[int'(r_sel)*ADDR_W +: ADDR_W];
  assign w_dst        = downstream_connections[(int'(r_sel)*MAX_FANOUT + int'(r_idx))*ADDR_W +: ADDR_W];
  assign packet       = r_valid ? {w_org, w_dst} : '0;
  assign packet_valid = r_valid;
  assign busy         = (r_state != IDLE) || (|r_pend);

`ifdef SPIKE_SCHED_COALESCE_CNT_EN
  logic [15:0]            r_coal_cnt;
  logic [NUM_NEURONS-1:0] w_merged;
  logic [15:0]            w_merge_num;
  logic [16:0]            w_coal_sum;

  assign w_merged = spikes & r_pend & ~w_clr_mask;

  always_comb begin
    w_merge_num = '0;
    for (int i = 0; i < NUM_NEURONS; i++) w_merge_num = w_merge_num + 16'(w_merged[i]);
  end

  assign w_coal_sum = {1'b0, r_coal_cnt} + {1'b0, w_merge_num};

  always_ff @(posedge CLK) begin
    if (clear)              r_coal_cnt <= '0;
    else if (w_coal_sum[16]) r_coal_cnt <= 16'hFFFF;
    else                    r_coal_cnt <= w_coal_sum[15:0];
  end

  assign coalesced_count = r_coal_cnt;
`endif

endmodule
